// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply sequencing controller:
// op encodings, FSM states, request/cache key bundles.
package mul_ctrl_pkg;

   localparam int MUL_XLEN    = 64;
   localparam int MUL_LATENCY = 34;

   localparam logic [1:0] MUL_OP_MUL    = 2'd0;
   localparam logic [1:0] MUL_OP_MULH   = 2'd1;
   localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
   localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   typedef struct packed {
      logic [MUL_XLEN-1:0] rs1;
      logic [MUL_XLEN-1:0] rs2;
      logic                s1;
      logic                s2;
   } mul_key_t;

   typedef struct packed {
      mul_key_t   key;
      logic [1:0] op;
      logic       word;
   } mul_req_t;

   // {rs1_sign, rs2_sign}; a word op is always a signed low multiply
   function automatic logic [1:0] op_signs(input logic [1:0] op,
                                           input logic       word);
      logic [1:0] s;
      s = 2'b11;
      if (!word) begin
         if (op == MUL_OP_MULHSU)
            s = 2'b10;
         else if (op == MUL_OP_MULHU)
            s = 2'b00;
      end
      return s;
   endfunction

endpackage

// File: rtl/mul_ctrl_if.sv
// Request/response handshake between execute and the
// multiply controller.
interface mul_ctrl_if;
   import mul_ctrl_pkg::*;

   logic                req_valid;
   logic                req_ready;
   logic [1:0]          req_op;
   logic                req_word;
   logic [MUL_XLEN-1:0] req_rs1;
   logic [MUL_XLEN-1:0] req_rs2;
   logic                resp_valid;
   logic                resp_ready;
   logic [MUL_XLEN-1:0] resp_data;

   modport master (
      output req_valid, req_op, req_word,
      output req_rs1, req_rs2, resp_ready,
      input  req_ready, resp_valid, resp_data
   );

   modport slave (
      input  req_valid, req_op, req_word,
      input  req_rs1, req_rs2, resp_ready,
      output req_ready, resp_valid, resp_data
   );

endinterface

// File: rtl/mul_result_sel.sv
// Picks the architectural result out of a 128-bit product:
// low half, high half, or sign-extended low word.
module mul_result_sel
   import mul_ctrl_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [2*XLEN-1:0] p,
   input  logic [1:0]        op,
   input  logic              word,
   output logic [XLEN-1:0]   res
);

   // word wins over op so an odd word/op combo behaves as MULW
   always_comb begin
      res = p[2*XLEN-1:XLEN];
      if (word)
         res = {{(XLEN-32){p[31]}}, p[31:0]};
      else if (op == MUL_OP_MUL)
         res = p[XLEN-1:0];
   end

endmodule

// File: rtl/mul_ctrl.sv
// Sequencer between execute and the shared Booth multiplier,
// with a one-entry product cache for MULH/MUL pairs.
module mul_ctrl
   import mul_ctrl_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter bit CACHE_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   mul_ctrl_if.slave         io,
   output logic              mul_valid,
   output logic              mul_rs1_sign,
   output logic              mul_rs2_sign,
   output logic [XLEN-1:0]   mul_rs1_data,
   output logic [XLEN-1:0]   mul_rs2_data,
   input  logic              mul_ready,
   input  logic [2*XLEN-1:0] mul_result
);

   logic [1:0]        state;
   mul_req_t          req_q;
   mul_key_t          req_key;
   mul_key_t          c_key;
   logic              c_vld;
   logic [2*XLEN-1:0] c_p;
   logic [XLEN-1:0]   resp_q;
   logic [1:0]        req_sg;
   logic              accept;
   logic              hit;
   logic              in_idle;
   logic [2*XLEN-1:0] sel_p;
   logic [1:0]        sel_op;
   logic              sel_word;
   logic [XLEN-1:0]   sel_res;

   assign in_idle      = (state == IDLE);
   assign req_sg       = op_signs(io.req_op, io.req_word);
   assign req_key      = {io.req_rs1, io.req_rs2, req_sg};
   assign io.req_ready = in_idle && !flush;
   assign accept       = io.req_valid && io.req_ready;
   assign hit          = CACHE_EN && c_vld && (c_key == req_key);

   assign io.resp_valid = (state == DONE);
   assign io.resp_data  = resp_q;

   assign mul_valid    = (state == BUSY) || (state == DRAIN);
   assign mul_rs1_sign = req_q.key.s1;
   assign mul_rs2_sign = req_q.key.s2;
   assign mul_rs1_data = req_q.key.rs1;
   assign mul_rs2_data = req_q.key.rs2;

   // hit path selects from the cache with the incoming op,
   // completion path from the live product with the latched op
   assign sel_p    = in_idle ? c_p         : mul_result;
   assign sel_op   = in_idle ? io.req_op   : req_q.op;
   assign sel_word = in_idle ? io.req_word : req_q.word;

   mul_result_sel #(
      .XLEN (XLEN)
   ) u_sel (
      .p    (sel_p),
      .op   (sel_op),
      .word (sel_word),
      .res  (sel_res)
   );

   // op sequencing; once started the multiply runs to mul_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         resp_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (hit) begin
                     state  <= DONE;
                     resp_q <= sel_res;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= mul_ready ? IDLE : DRAIN;
               end else if (mul_ready) begin
                  state  <= DONE;
                  resp_q <= sel_res;
               end
            end
            DRAIN: begin
               if (mul_ready)
                  state <= IDLE;
            end
            DONE: begin
               if (flush || io.resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // operands and op captured at accept, held for the multiplier
   always_ff @(posedge clk) begin
      if (rst)
         req_q <= '0;
      else if (accept)
         req_q <= '{key: req_key, op: io.req_op, word: io.req_word};
   end

   // every finished product is cached, even for a killed op
   always_ff @(posedge clk) begin
      if (rst) begin
         c_vld <= 1'b0;
         c_key <= '0;
         c_p   <= '0;
      end else if (mul_valid && mul_ready) begin
         c_vld <= 1'b1;
         c_key <= req_q.key;
         c_p   <= mul_result;
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl with a behavioural
// 34-cycle multiplier and an arithmetic reference model.
module tb_mul_ctrl;
   import mul_ctrl_pkg::*;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          mul_valid;
   logic          mul_rs1_sign;
   logic          mul_rs2_sign;
   logic [63:0]   mul_rs1_data;
   logic [63:0]   mul_rs2_data;
   logic          mul_ready;
   logic [127:0]  mul_result;
   logic [5:0]    mcnt;
   logic signed [129:0] pa, pb, pp;

   int n_chk  = 0;
   int n_pass = 0;

   logic         mc_vld;
   logic [129:0] mc_key;

   mul_ctrl_if io();

   mul_ctrl #(
      .XLEN     (64),
      .CACHE_EN (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .io           (io),
      .mul_valid    (mul_valid),
      .mul_rs1_sign (mul_rs1_sign),
      .mul_rs2_sign (mul_rs2_sign),
      .mul_rs1_data (mul_rs1_data),
      .mul_rs2_data (mul_rs2_data),
      .mul_ready    (mul_ready),
      .mul_result   (mul_result)
   );

   always #5 clk = ~clk;

   // multiplier model: ready on the 34th consecutive valid cycle
   assign mul_ready = mul_valid && (mcnt == 6'(MUL_LATENCY - 1));

   always @(posedge clk) begin
      if (rst || !mul_valid || mul_ready)
         mcnt <= '0;
      else
         mcnt <= mcnt + 6'd1;
   end

   always_comb begin
      pa = mul_rs1_sign ? {{66{mul_rs1_data[63]}}, mul_rs1_data}
                        : {66'b0, mul_rs1_data};
      pb = mul_rs2_sign ? {{66{mul_rs2_data[63]}}, mul_rs2_data}
                        : {66'b0, mul_rs2_data};
      pp = pa * pb;
      mul_result = pp[127:0];
   end

   function automatic logic [63:0] ref_mul(input logic [1:0] op,
      input logic w, input logic [63:0] a, input logic [63:0] b);
      logic [31:0] lw;
      logic [63:0] lo;
      logic signed [128:0] sa, sb, p;
      lw = a[31:0] * b[31:0];
      lo = a * b;
      sa = (op == MUL_OP_MULHU) ? {65'b0, a} : {{65{a[63]}}, a};
      sb = (op == MUL_OP_MULH)  ? {{65{b[63]}}, b} : {65'b0, b};
      p  = sa * sb;
      if (w)
         return {{32{lw[31]}}, lw};
      if (op == MUL_OP_MUL)
         return lo;
      return p[127:64];
   endfunction

   function automatic logic [129:0] ref_key(input logic [1:0] op,
      input logic w, input logic [63:0] a, input logic [63:0] b);
      logic s1, s2;
      s1 = w || (op != MUL_OP_MULHU);
      s2 = w || (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
      return {a, b, s1, s2};
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // present one request in IDLE; model predicts hit and data
   task automatic issue(input logic [1:0] op, input logic w,
      input logic [63:0] a, input logic [63:0] b,
      output logic hit, output logic [63:0] exp);
      logic [129:0] k;
      k      = ref_key(op, w, a, b);
      hit    = mc_vld && (mc_key == k);
      exp    = ref_mul(op, w, a, b);
      mc_vld = 1'b1;
      mc_key = k;
      io.req_op    = op;
      io.req_word  = w;
      io.req_rs1   = a;
      io.req_rs2   = b;
      io.req_valid = 1'b1;
      step();
      io.req_valid = 1'b0;
   endtask

   // lat counts cycles from accept; mv counts mul_valid cycles
   task automatic wait_resp(output int lat, output int mv);
      lat = 1;
      mv  = 0;
      while (!io.resp_valid && lat < 200) begin
         if (mul_valid) mv++;
         step();
         lat++;
      end
   endtask

   task automatic consume;
      io.resp_ready = 1'b1;
      step();
      io.resp_ready = 1'b0;
   endtask

   task automatic test_reset;
      n_chk++;
      if (io.req_ready !== 1'b1)
         $display("FAIL reset_req_ready got %b want 1", io.req_ready);
      else n_pass++;
      n_chk++;
      if (io.resp_valid !== 1'b0)
         $display("FAIL reset_resp_valid got %b want 0", io.resp_valid);
      else n_pass++;
      n_chk++;
      if (io.resp_data !== 64'd0)
         $display("FAIL reset_resp_data got %h want 0", io.resp_data);
      else n_pass++;
      n_chk++;
      if ({mul_valid, mul_rs1_sign, mul_rs2_sign} !== 3'b000)
         $display("FAIL reset_mul_ctl got %b want 000",
                  {mul_valid, mul_rs1_sign, mul_rs2_sign});
      else n_pass++;
      n_chk++;
      if ({mul_rs1_data, mul_rs2_data} !== 128'd0)
         $display("FAIL reset_mul_data got %h %h want 0",
                  mul_rs1_data, mul_rs2_data);
      else n_pass++;
   endtask

   task automatic test_ops;
      logic [1:0]  t_op [5];
      logic        t_w  [5];
      logic [63:0] t_a  [5];
      logic [63:0] t_b  [5];
      logic [63:0] t_r  [5];
      logic        hit;
      logic [63:0] exp;
      int          lat, mv;
      t_op[0] = MUL_OP_MUL;    t_w[0] = 0; t_a[0] = 64'd3;
      t_b[0]  = 64'd5;         t_r[0] = 64'd15;
      t_op[1] = MUL_OP_MULHU;  t_w[1] = 0; t_a[1] = '1;
      t_b[1]  = '1;            t_r[1] = 64'hFFFF_FFFF_FFFF_FFFE;
      t_op[2] = MUL_OP_MULHSU; t_w[2] = 0; t_a[2] = '1;
      t_b[2]  = 64'd2;         t_r[2] = '1;
      t_op[3] = MUL_OP_MULH;   t_w[3] = 0; t_a[3] = '1;
      t_b[3]  = '1;            t_r[3] = 64'd0;
      t_op[4] = MUL_OP_MUL;    t_w[4] = 1; t_a[4] = 64'h7FFF_FFFF;
      t_b[4]  = 64'd2;         t_r[4] = 64'hFFFF_FFFF_FFFF_FFFE;
      for (int i = 0; i < 5; i++) begin
         issue(t_op[i], t_w[i], t_a[i], t_b[i], hit, exp);
         wait_resp(lat, mv);
         n_chk++;
         if (lat != (hit ? 1 : 35))
            $display("FAIL ops_lat[%0d] got %0d want %0d",
                     i, lat, hit ? 1 : 35);
         else n_pass++;
         n_chk++;
         if (mv != (hit ? 0 : 34))
            $display("FAIL ops_mulvalid[%0d] got %0d want %0d",
                     i, mv, hit ? 0 : 34);
         else n_pass++;
         n_chk++;
         if (io.resp_data !== t_r[i])
            $display("FAIL ops_data[%0d] got %h want %h",
                     i, io.resp_data, t_r[i]);
         else n_pass++;
         n_chk++;
         if (io.resp_data !== exp)
            $display("FAIL ops_model[%0d] got %h want %h",
                     i, io.resp_data, exp);
         else n_pass++;
         consume();
         n_chk++;
         if ({io.resp_valid, io.req_ready} !== 2'b01)
            $display("FAIL ops_release[%0d] got %b want 01",
                     i, {io.resp_valid, io.req_ready});
         else n_pass++;
      end
   endtask

   task automatic test_cache;
      logic [1:0]  t_op [3];
      int          t_lat [3];
      logic [63:0] a, b, exp;
      logic        hit;
      int          lat, mv;
      a = 64'h1234_5678_9ABC_DEF0;
      b = -64'sd7;
      t_op[0] = MUL_OP_MULH;  t_lat[0] = 35;
      t_op[1] = MUL_OP_MUL;   t_lat[1] = 1;
      t_op[2] = MUL_OP_MULHU; t_lat[2] = 35;
      for (int i = 0; i < 3; i++) begin
         issue(t_op[i], 1'b0, a, b, hit, exp);
         wait_resp(lat, mv);
         n_chk++;
         if (lat != t_lat[i])
            $display("FAIL cache_lat[%0d] got %0d want %0d",
                     i, lat, t_lat[i]);
         else n_pass++;
         n_chk++;
         if (mv != ((t_lat[i] == 1) ? 0 : 34))
            $display("FAIL cache_mulvalid[%0d] got %0d want %0d",
                     i, mv, (t_lat[i] == 1) ? 0 : 34);
         else n_pass++;
         n_chk++;
         if (io.resp_data !== exp)
            $display("FAIL cache_data[%0d] got %h want %h",
                     i, io.resp_data, exp);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_flush_busy;
      logic [63:0] x, y, exp;
      logic        hit, rv;
      int          lat, mv;
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      issue(MUL_OP_MUL, 1'b0, x, y, hit, exp);
      lat = 1;
      rv  = 1'b0;
      repeat (9) begin
         step();
         lat++;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      lat++;
      while (!io.req_ready && lat < 200) begin
         if (io.resp_valid) rv = 1'b1;
         step();
         lat++;
      end
      n_chk++;
      if (lat != 35)
         $display("FAIL flush_busy_ready got %0d want 35", lat);
      else n_pass++;
      n_chk++;
      if ((rv | io.resp_valid) !== 1'b0)
         $display("FAIL flush_busy_resp got %b want 0",
                  rv | io.resp_valid);
      else n_pass++;
      issue(MUL_OP_MULH, 1'b0, x, y, hit, exp);
      wait_resp(lat, mv);
      n_chk++;
      if (lat != 1)
         $display("FAIL flush_busy_cached got %0d want 1", lat);
      else n_pass++;
      n_chk++;
      if (io.resp_data !== exp)
         $display("FAIL flush_busy_hitdata got %h want %h",
                  io.resp_data, exp);
      else n_pass++;
      consume();
      issue(MUL_OP_MUL, 1'b0, 64'd6, 64'd7, hit, exp);
      wait_resp(lat, mv);
      n_chk++;
      if (io.resp_data !== 64'd42 || lat != 35)
         $display("FAIL flush_next got %0d lat %0d want 42 lat 35",
                  io.resp_data, lat);
      else n_pass++;
      consume();
   endtask

   task automatic test_flush_idle;
      flush        = 1'b1;
      io.req_op    = MUL_OP_MUL;
      io.req_word  = 1'b0;
      io.req_rs1   = 64'd9;
      io.req_rs2   = 64'd9;
      io.req_valid = 1'b1;
      #1;
      n_chk++;
      if (io.req_ready !== 1'b0)
         $display("FAIL flush_idle_ready got %b want 0", io.req_ready);
      else n_pass++;
      step();
      n_chk++;
      if ({mul_valid, io.resp_valid} !== 2'b00)
         $display("FAIL flush_idle_accept got %b want 00",
                  {mul_valid, io.resp_valid});
      else n_pass++;
      io.req_valid = 1'b0;
      flush        = 1'b0;
      #1;
      n_chk++;
      if (io.req_ready !== 1'b1)
         $display("FAIL flush_idle_recover got %b want 1", io.req_ready);
      else n_pass++;
   endtask

   task automatic test_backpressure;
      logic [63:0] exp;
      logic        hit;
      int          lat, mv;
      issue(MUL_OP_MULHU, 1'b0, {$urandom, $urandom},
            {$urandom, $urandom}, hit, exp);
      wait_resp(lat, mv);
      for (int j = 0; j < 5; j++) begin
         step();
         n_chk++;
         if ({io.resp_valid, io.req_ready} !== 2'b10 ||
             io.resp_data !== exp)
            $display("FAIL hold[%0d] got v/r %b data %h want 10 %h",
                     j, {io.resp_valid, io.req_ready},
                     io.resp_data, exp);
         else n_pass++;
      end
      consume();
   endtask

   task automatic test_flush_done;
      logic [63:0] exp;
      logic        hit;
      int          lat, mv;
      issue(MUL_OP_MULHSU, 1'b0, {$urandom, $urandom},
            {$urandom, $urandom}, hit, exp);
      wait_resp(lat, mv);
      n_chk++;
      if (io.resp_valid !== 1'b1)
         $display("FAIL flush_done_valid got %b want 1", io.resp_valid);
      else n_pass++;
      flush         = 1'b1;
      io.resp_ready = 1'b1;
      step();
      flush         = 1'b0;
      io.resp_ready = 1'b0;
      #1;
      n_chk++;
      if ({io.resp_valid, io.req_ready} !== 2'b01)
         $display("FAIL flush_done_idle got %b want 01",
                  {io.resp_valid, io.req_ready});
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      logic [63:0] a, b, exp;
      logic        hit;
      int          lat, mv;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      issue(MUL_OP_MULH, 1'b0, a, b, hit, exp);
      repeat (19) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      mc_vld = 1'b0;
      #1;
      n_chk++;
      if ({io.req_ready, io.resp_valid, mul_valid} !== 3'b100 ||
          io.resp_data !== 64'd0 ||
          {mul_rs1_data, mul_rs2_data} !== 128'd0)
         $display("FAIL rst_mid got r/v/m %b data %h want 100 0",
                  {io.req_ready, io.resp_valid, mul_valid},
                  io.resp_data);
      else n_pass++;
      issue(MUL_OP_MULH, 1'b0, a, b, hit, exp);
      wait_resp(lat, mv);
      n_chk++;
      if (lat != 35 || mv != 34)
         $display("FAIL rst_mid_lat got %0d/%0d want 35/34", lat, mv);
      else n_pass++;
      n_chk++;
      if (io.resp_data !== exp)
         $display("FAIL rst_mid_data got %h want %h",
                  io.resp_data, exp);
      else n_pass++;
      consume();
   endtask

   task automatic test_random;
      logic [63:0] pool [4];
      logic [63:0] exp;
      logic [1:0]  op;
      logic        w, hit;
      int          lat, mv, hold;
      pool[0] = '1;
      pool[1] = {$urandom, $urandom};
      pool[2] = 64'h8000_0000_0000_0000;
      pool[3] = {32'd0, $urandom};
      for (int i = 0; i < 40; i++) begin
         op   = 2'($urandom_range(0, 3));
         w    = ($urandom_range(0, 3) == 0);
         hold = $urandom_range(0, 2);
         issue(op, w, pool[$urandom_range(0, 3)],
               pool[$urandom_range(0, 3)], hit, exp);
         wait_resp(lat, mv);
         n_chk++;
         if (lat != (hit ? 1 : 35) || mv != (hit ? 0 : 34))
            $display("FAIL rnd_lat[%0d] got %0d/%0d want %0d/%0d",
                     i, lat, mv, hit ? 1 : 35, hit ? 0 : 34);
         else n_pass++;
         n_chk++;
         if (io.resp_data !== exp)
            $display("FAIL rnd_data[%0d] op %0d w %b got %h want %h",
                     i, op, w, io.resp_data, exp);
         else n_pass++;
         for (int j = 0; j < hold; j++) begin
            step();
            n_chk++;
            if (io.resp_valid !== 1'b1 || io.resp_data !== exp)
               $display("FAIL rnd_hold[%0d] got %b %h want 1 %h",
                        i, io.resp_valid, io.resp_data, exp);
            else n_pass++;
         end
         consume();
      end
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      io.req_valid  = 1'b0;
      io.req_op     = '0;
      io.req_word   = 1'b0;
      io.req_rs1    = '0;
      io.req_rs2    = '0;
      io.resp_ready = 1'b0;
      mc_vld        = 1'b0;
      mc_key        = '0;
      repeat (3) step();
      rst = 1'b0;
      #1;
      test_reset();
      test_ops();
      test_cache();
      test_flush_busy();
      test_flush_idle();
      test_backpressure();
      test_flush_done();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul_ctrl.md
Name: mul_ctrl

Overview:
- Sequencing controller between the execute stage and the shared 33-step radix-4 Booth multiplier.
- Accepts RV64M multiply ops (MUL/MULH/MULHSU/MULHU/MULW) over a valid/ready handshake.
- Drives the multiplier's hold-valid protocol and extracts/sign-extends the 64-bit result.
- Keeps a one-entry product cache, so a MULH/MUL pair on identical operands issues only one 34-cycle multiply.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.
- CACHE_EN, 1, enables the one-entry product cache; 0 forces a miss on every request.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  pipeline kill; discards the in-flight op
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_op  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- req_word  in  1  MULW; legal only with req_op=0
- req_rs1  in  64  operand 1
- req_rs2  in  64  operand 2
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  64  result
- mul_valid  out  1  to multiplier; held high for the whole operation
- mul_rs1_sign  out  1  to multiplier
- mul_rs2_sign  out  1  to multiplier
- mul_rs1_data  out  64  to multiplier
- mul_rs2_data  out  64  to multiplier
- mul_ready  in  1  multiplier done; single-cycle pulse
- mul_result  in  128  product, valid while mul_ready=1

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. The multiplier shares the same rst. On reset: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, mul_valid=0, mul_* data/sign=0, cache invalid.
- Signs:
  - MUL/MULW/MULH: (1,1)
  - MULHSU: (1,0)
  - MULHU: (0,0)
- Result select from the 128-bit product P:
  - MUL: P[63:0]
  - MULH/MULHSU/MULHU: P[127:64]
  - MULW: sign-extend P[31:0]
- req_ready = (state==IDLE) && !flush. A request is accepted on a cycle with req_valid && req_ready; operands, signs and op are latched into registers.
- States:
  - IDLE: on accept with cache hit -> DONE; with miss -> BUSY.
  - BUSY: mul_valid=1, mul_* driven from latched registers. On mul_ready: capture P into the cache and the selected result into resp_data -> DONE. On flush (without mul_ready) -> DRAIN.
  - DRAIN: mul_valid=1. The multiplier cannot be aborted because it only freezes when valid drops. On mul_ready: update the cache, produce no response -> IDLE.
  - DONE: resp_valid=1 and resp_data held stable until resp_ready -> IDLE. On flush -> IDLE, response dropped, resp_valid=0 next cycle.
- Latency:
  - Miss: accept at T; mul_valid high T+1..T+34; mul_ready at T+34; resp_valid at T+35.
  - Hit: resp_valid at T+1.
- mul_valid must never drop between the first BUSY cycle and mul_ready. It is low in IDLE and DONE, so the multiplier counter restarts at 0 for each op.
- Cache:
  - Key = {rs1, rs2, rs1_sign, rs2_sign}; data = 128-bit P.
  - Hit requires valid && key match.
  - Updated on every mul_ready, including in DRAIN.
  - Invalidated only by rst.
- Simultaneous events:
  - flush with mul_ready in BUSY: flush wins; cache updated; -> IDLE with no response.
  - flush with req_valid in IDLE: request not accepted.
  - flush with resp_ready in DONE: response counts as dropped.
- Illegal req_word with req_op!=0: treated as MULW.
- Reset mid-operation: all state cleared, no response, cache invalid.

Decomposition:
- Shared package: op encodings (MUL_OP_*), state encoding (IDLE/BUSY/DRAIN/DONE), MUL_LATENCY=34.
- One sub-module: mul_result_sel, a combinational block taking (P, op, word) and returning the 64-bit result. It is used on both the mul_ready path and the cache-hit path.

Test Plan:
- MUL 3*5: resp_data=15; resp_valid exactly 35 cycles after accept; mul_valid high for 34 consecutive cycles.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULHSU rs1=-1, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULH rs1=rs2=-1 -> 0.
- MULW rs1=0x7FFF_FFFF, rs2=2 -> 0xFFFF_FFFF_FFFF_FFFE.
- MULH a=0x1234_5678_9ABC_DEF0, b=-7, then MUL a,b -> second resp_valid 1 cycle after accept, no mul_valid pulse; then MULHU a,b -> miss, full 35-cycle latency.
- Flush 10 cycles after accept -> no resp_valid; req_ready stays 0 until the cycle after mul_ready (T+35); next MUL 6*7=42 is correct.
- resp_ready held low 5 cycles in DONE -> resp_data stable, req_ready=0. Flush asserted in DONE -> resp_valid clears and state returns to IDLE. rst at cycle 20 of BUSY -> outputs at reset values; next op correct with full latency.
